grover_readout: RTL and testbench

Measurement back-end for the `grover` amplitude engine. It samples the eight state amplitudes when `grover` signals completion and scans them serially, one lane per cycle. It reports the most probable basis index, that index's squared magnitude, and the total squared-magnitude sum over a valid/ready handshake. It sits directly downstream of `grover` and is the consumer end of its `o0..o7`/`done` interface.

---
 rtl/grover_pkg.sv | 10 +
 rtl/grover_sq_acc.sv | 59 +++++
 rtl/grover_readout.sv | 110 +++++++++++
 tb/tb_grover_readout.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/grover_pkg.sv
// Shared widths, lane count and FSM encoding for the grover measurement back-end.
package grover_pkg;
    localparam int AMP_W = 8;
    localparam int N_ST  = 8;
    localparam int IDX_W = $clog2(N_ST);
    localparam int SQ_W  = 2*AMP_W;
    localparam int TOT_W = 2*AMP_W + 3;

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_e;
endpackage

// File: rtl/grover_sq_acc.sv
// Per-lane squarer feeding a running sum and a strict-greater argmax register.
// Next-state values are exported so the caller can latch the final lane's result on the same edge.
module grover_sq_acc
    import grover_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [AMP_W-1:0] amp_i,
    input  logic [IDX_W-1:0] lane_i,
    output logic [TOT_W-1:0] total_d_o,
    output logic [SQ_W-1:0]  best_prob_d_o,
    output logic [IDX_W-1:0] best_idx_d_o
);
    logic [TOT_W-1:0]        total_q, total_d;
    logic [SQ_W-1:0]         best_prob_q, best_prob_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic signed [SQ_W-1:0]  amp_ext, prod;
    logic [SQ_W-1:0]         sq;

    // Sign-extend before multiplying so the low SQ_W bits are the exact square (-128^2 = 16384).
    assign amp_ext = {{AMP_W{amp_i[AMP_W-1]}}, amp_i};
    assign prod    = amp_ext * amp_ext;
    assign sq      = prod;

    always_comb begin
        total_d     = total_q;
        best_prob_d = best_prob_q;
        best_idx_d  = best_idx_q;
        if (clr_i) begin
            total_d     = '0;
            best_prob_d = '0;
            best_idx_d  = '0;
        end else if (en_i) begin
            total_d = total_q + TOT_W'(sq);
            if (sq > best_prob_q) begin
                best_prob_d = sq;
                best_idx_d  = lane_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q     <= '0;
            best_prob_q <= '0;
            best_idx_q  <= '0;
        end else begin
            total_q     <= total_d;
            best_prob_q <= best_prob_d;
            best_idx_q  <= best_idx_d;
        end
    end

    assign total_d_o     = total_d;
    assign best_prob_d_o = best_prob_d;
    assign best_idx_d_o  = best_idx_d;
endmodule

// File: rtl/grover_readout.sv
// Captures the eight grover amplitudes on a done edge, scans them one lane per cycle,
// and presents argmax index, its squared magnitude and the total over valid/ready.
module grover_readout
    import grover_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic [AMP_W-1:0] amp0,
    input  logic [AMP_W-1:0] amp1,
    input  logic [AMP_W-1:0] amp2,
    input  logic [AMP_W-1:0] amp3,
    input  logic [AMP_W-1:0] amp4,
    input  logic [AMP_W-1:0] amp5,
    input  logic [AMP_W-1:0] amp6,
    input  logic [AMP_W-1:0] amp7,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [IDX_W-1:0] meas_idx,
    output logic [SQ_W-1:0]  meas_prob,
    output logic [TOT_W-1:0] total,
    output logic             busy,
    output logic             overrun
);
    logic [N_ST-1:0][AMP_W-1:0] amp_in, cap_q;
    state_e                     state_q;
    logic                       done_q, trig;
    logic [IDX_W-1:0]           lane_q;
    logic                       busy_q, res_valid_q, overrun_q;
    logic [IDX_W-1:0]           meas_idx_q;
    logic [SQ_W-1:0]            meas_prob_q;
    logic [TOT_W-1:0]           total_q;
    logic                       acc_clr, acc_en, last_lane;
    logic [TOT_W-1:0]           acc_total_d;
    logic [SQ_W-1:0]            acc_prob_d;
    logic [IDX_W-1:0]           acc_idx_d;

    assign amp_in    = {amp7, amp6, amp5, amp4, amp3, amp2, amp1, amp0};
    assign trig      = done & ~done_q;
    assign acc_clr   = (state_q == IDLE) & trig;
    assign acc_en    = (state_q == SCAN);
    assign last_lane = (lane_q == IDX_W'(N_ST-1));

    grover_sq_acc u_acc (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (acc_clr),
        .en_i          (acc_en),
        .amp_i         (cap_q[lane_q]),
        .lane_i        (lane_q),
        .total_d_o     (acc_total_d),
        .best_prob_d_o (acc_prob_d),
        .best_idx_d_o  (acc_idx_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            cap_q       <= '0;
            lane_q      <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            meas_idx_q  <= '0;
            meas_prob_q <= '0;
            total_q     <= '0;
        end else begin
            done_q <= done;
            // A trigger while busy (including the accept cycle) is flagged and dropped.
            if (trig && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        cap_q   <= amp_in;
                        lane_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    lane_q <= lane_q + IDX_W'(1);
                    if (last_lane) begin
                        meas_idx_q  <= acc_idx_d;
                        meas_prob_q <= acc_prob_d;
                        total_q     <= acc_total_d;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign meas_idx  = meas_idx_q;
    assign meas_prob = meas_prob_q;
    assign total     = total_q;
endmodule

// File: tb/tb_grover_readout.sv
// Directed plus randomized checks of grover_readout against a square/sum/argmax reference.
module tb_grover_readout;
    import grover_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             done;
    logic             res_ready;
    logic signed [AMP_W-1:0] av [N_ST];
    logic             res_valid, busy, overrun;
    logic [IDX_W-1:0] meas_idx;
    logic [SQ_W-1:0]  meas_prob;
    logic [TOT_W-1:0] total;

    int n_chk  = 0;
    int n_fail = 0;
    int ref_idx, ref_prob, ref_total;

    grover_readout dut (
        .clk(clk), .rst(rst), .done(done),
        .amp0(av[0]), .amp1(av[1]), .amp2(av[2]), .amp3(av[3]),
        .amp4(av[4]), .amp5(av[5]), .amp6(av[6]), .amp7(av[7]),
        .res_ready(res_ready), .res_valid(res_valid), .meas_idx(meas_idx),
        .meas_prob(meas_prob), .total(total), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Squares first, then sum, max, and the first index holding the max.
    function automatic void model();
        int sq [N_ST];
        ref_total = 0;
        ref_prob  = 0;
        ref_idx   = 0;
        foreach (sq[k]) begin
            sq[k] = int'(av[k]) * int'(av[k]);
            ref_total += sq[k];
            if (sq[k] > ref_prob) ref_prob = sq[k];
        end
        for (int k = N_ST-1; k >= 0; k--)
            if (sq[k] == ref_prob) ref_idx = k;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, ".idx"},   64'(meas_idx),  64'(ref_idx));
        chk({tag, ".prob"},  64'(meas_prob), 64'(ref_prob));
        chk({tag, ".total"}, 64'(total),     64'(ref_total));
    endtask

    task automatic set_all(input int v);
        foreach (av[k]) av[k] = AMP_W'(v);
    endtask

    task automatic rand_amps();
        int picks [5] = '{127, -128, -3, 0, 90};
        foreach (av[k]) begin
            if ($urandom_range(0, 3) == 0) av[k] = AMP_W'(picks[$urandom_range(0, 4)]);
            else                           av[k] = AMP_W'($urandom_range(0, 255));
        end
    endtask

    // Called at a negedge with done low; returns at the negedge where res_valid rose.
    task automatic scan(input string tag, input bit ready, input bit scramble);
        int n;
        model();
        res_ready = ready;
        done = 1'b1;
        @(posedge clk); n = 1; @(negedge clk);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        if (scramble) rand_amps();
        while (!res_valid && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        chk({tag, ".latency"}, 64'(n), 64'd9);
        chk_fields(tag);
        done = 1'b0;
    endtask

    task automatic accept(input string tag);
        @(posedge clk); @(negedge clk);
        chk({tag, ".vld_after_acc"},  64'(res_valid), 64'd0);
        chk({tag, ".busy_after_acc"}, 64'(busy),      64'd0);
        chk_fields({tag, ".held"});
    endtask

    initial begin
        int cnt;
        rst = 1'b1; done = 1'b0; res_ready = 1'b0;
        set_all(0);
        repeat (2) @(negedge clk);
        chk("rst.valid",   64'(res_valid), 64'd0);
        chk("rst.busy",    64'(busy),      64'd0);
        chk("rst.overrun", 64'(overrun),   64'd0);
        chk("rst.idx",     64'(meas_idx),  64'd0);
        chk("rst.prob",    64'(meas_prob), 64'd0);
        chk("rst.total",   64'(total),     64'd0);
        rst = 1'b0;
        @(negedge clk);

        set_all(-11); av[0] = 8'sd124;
        scan("typ", 1'b1, 1'b0);
        chk("typ.idx_c",   64'(meas_idx),  64'd0);
        chk("typ.prob_c",  64'(meas_prob), 64'd15376);
        chk("typ.total_c", 64'(total),     64'd16223);
        accept("typ");

        set_all(0); av[3] = -8'sd90; av[5] = -8'sd90;
        scan("tie", 1'b1, 1'b0);
        chk("tie.idx_c",   64'(meas_idx),  64'd3);
        chk("tie.total_c", 64'(total),     64'd16200);
        accept("tie");

        set_all(0);
        scan("zero", 1'b1, 1'b0);
        accept("zero");

        set_all(-128);
        scan("ext", 1'b1, 1'b0);
        chk("ext.prob_c",  64'(meas_prob), 64'd16384);
        chk("ext.total_c", 64'(total),     64'd131072);
        accept("ext");

        for (int i = 0; i < 16; i++) begin
            rand_amps();
            scan("rnd", 1'b1, 1'b0);
            accept("rnd");
        end
        chk("pre_bp.overrun", 64'(overrun), 64'd0);

        rand_amps();
        scan("bp", 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            done = (i == 5);
            @(posedge clk); @(negedge clk);
            chk("bp.valid", 64'(res_valid), 64'd1);
            chk_fields("bp.stable");
        end
        done = 1'b0;
        chk("bp.overrun", 64'(overrun), 64'd1);
        res_ready = 1'b1;
        accept("bp");
        cnt = 0;
        repeat (15) begin
            @(posedge clk); @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("bp.no_second", 64'(cnt), 64'd0);

        rand_amps(); model();
        done = 1'b1; cnt = 0;
        repeat (30) begin
            @(posedge clk); @(negedge clk);
            if (res_valid) begin
                cnt++;
                chk_fields("lvl");
            end
        end
        done = 1'b0;
        chk("lvl.count", 64'(cnt), 64'd1);
        @(negedge clk);

        set_all(77); av[6] = -8'sd100;
        scan("iso", 1'b1, 1'b1);
        chk("iso.idx_c", 64'(meas_idx), 64'd6);
        accept("iso");

        rand_amps();
        done = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst.valid",   64'(res_valid), 64'd0);
        chk("arst.busy",    64'(busy),      64'd0);
        chk("arst.overrun", 64'(overrun),   64'd0);
        chk("arst.idx",     64'(meas_idx),  64'd0);
        chk("arst.prob",    64'(meas_prob), 64'd0);
        chk("arst.total",   64'(total),     64'd0);
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.idle", 64'(busy), 64'd0);
        rand_amps();
        scan("post_rst", 1'b1, 1'b0);
        accept("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
